// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with FIFO-buffered load responses
// into one registered register-file write port, and tracks loads still in flight.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wen,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        regwrite,
    output logic [4:0]  writereg_addr,
    output logic [31:0] writedata
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          alu_sel;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [4:0]    win_rd;
    logic [31:0]   win_data;
    logic          win_valid;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign ld_ready  = !full;
    assign push      = ld_valid && !full;
    assign head_rd   = mem[rd_ptr][36:32];
    assign head_data = mem[rd_ptr][31:0];

    // A full FIFO takes priority so load responses cannot be starved by a busy ALU.
    assign pop       = !empty && (full || !alu_wen);
    assign alu_sel   = alu_wen && !full;
    assign alu_stall = alu_wen && full;

    assign win_valid = pop || alu_sel;
    assign win_rd    = pop ? head_rd   : alu_rd;
    assign win_data  = pop ? head_data : alu_data;

    assign busy_rs1  = busy[rs1_addr];
    assign busy_rs2  = busy[rs2_addr];

    // Clear-then-set ordering makes a newly issued load win over a same-cycle writeback.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 5'd0) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ld_rd, ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            busy          <= '0;
            regwrite      <= 1'b0;
            writereg_addr <= 5'd0;
            writedata     <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busy     <= busy_next;
            regwrite <= win_valid && (win_rd != 5'd0);
            if (win_valid && win_rd != 5'd0) begin
                writereg_addr <= win_rd;
                writedata     <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based
// model; a negedge monitor checks every writeback against the expected-write queue.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        alu_wen;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        regwrite;
    logic [4:0]  writereg_addr;
    logic [31:0] writedata;

    wb_arbiter #(.DEPTH(DEPTH), .AW(1)) dut (
        .clk(clk), .rst(rst),
        .alu_wen(alu_wen), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .regwrite(regwrite), .writereg_addr(writereg_addr), .writedata(writedata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [36:0] exp_q[$];
    int unsigned exp_cyc[$];
    int          checks = 0;
    int          errors = 0;

    // reference model: load queue in arrival order and a set of pending destinations
    logic [36:0] m_fifo[$];
    bit          m_busy[32];
    bit          m_stall;
    bit          m_ld_blocked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_idle();
        alu_wen   = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    // Inputs are already applied; check combinational outputs, advance the model, clock once.
    task automatic step();
        bit          full;
        bit          pop;
        bit          alu_win;
        logic [36:0] head;
        logic [36:0] win;
        #2;
        if (!rst) begin
            m_fifo.delete();
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_stall      = 1'b0;
            m_ld_blocked = 1'b0;
        end else begin
            full    = (m_fifo.size() == DEPTH);
            pop     = (m_fifo.size() != 0) && (full || !alu_wen);
            alu_win = alu_wen && !full;
            chk("ld_ready", ld_ready, !full);
            chk("alu_stall", alu_stall, alu_wen && full);
            chk("busy_rs1", busy_rs1, m_busy[rs1_addr]);
            chk("busy_rs2", busy_rs2, m_busy[rs2_addr]);
            m_stall      = alu_wen && full;
            m_ld_blocked = ld_valid && full;
            win  = '0;
            head = '0;
            if (pop) begin
                head = m_fifo.pop_front();
                win  = head;
                m_busy[head[36:32]] = 1'b0;
            end else if (alu_win) begin
                win = {alu_rd, alu_data};
            end
            if ((pop || alu_win) && win[36:32] != 5'd0) begin
                exp_q.push_back(win);
                exp_cyc.push_back(cyc + 1);
            end
            if (ld_valid && !full) m_fifo.push_back({ld_rd, ld_data});
            if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        set_idle();
        rst = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [4:0]  mon_addr = 5'd0;
    logic [31:0] mon_data = 32'd0;
    bit          mon_rst_seen = 1'b0;
    bit          mon_on = 1'b0;

    always @(negedge clk) begin
        logic [36:0] e;
        if (mon_rst_seen) begin
            mon_addr = 5'd0;
            mon_data = 32'd0;
        end
        mon_rst_seen = !rst;
        if (mon_on) begin
            if (exp_cyc.size() != 0 && exp_cyc[0] == cyc) begin
                void'(exp_cyc.pop_front());
                e = exp_q.pop_front();
                chk("regwrite", regwrite, 1);
                chk("writereg_addr", writereg_addr, e[36:32]);
                chk("writedata", writedata, e[31:0]);
                mon_addr = e[36:32];
                mon_data = e[31:0];
            end else begin
                chk("regwrite_idle", regwrite, 0);
                chk("hold_addr", writereg_addr, mon_addr);
                chk("hold_data", writedata, mon_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit pend_alu;
        bit pend_ld;
        rst = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        set_idle();
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        do_reset(2);
        chk("reset_writereg_addr", writereg_addr, 0);
        chk("reset_writedata", writedata, 0);

        // idle then single ALU write
        for (int i = 0; i < 3; i++) step();
        alu_wen = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        set_idle();
        step();

        // issued load marks x7 busy until its response writes back
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        set_idle();
        rs1_addr = 5'd7;
        step();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
        step();
        set_idle();
        for (int i = 0; i < 3; i++) step();

        // busy ALU stream while two loads arrive
        iss_valid = 1'b1; iss_rd = 5'd10; rs2_addr = 5'd10;
        step();
        iss_rd = 5'd11; rs1_addr = 5'd11;
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alu_wen = 1'b1; alu_rd = 5'd3; alu_data = 32'hA000_0000 + i;
            ld_valid = (i < 2); ld_rd = (i == 0) ? 5'd10 : 5'd11; ld_data = 32'hB000_0000 + i;
            step();
        end
        set_idle();
        step();

        // writes to x0 are consumed silently; x0 is never busy
        alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 32'h1111;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h2222;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        step();
        set_idle();
        step();
        step();

        // pop of x9 coincides with a new issue to x9
        iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9;
        step();
        set_idle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999;
        step();
        set_idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        set_idle();
        step();
        chk("busy9_after_pop", busy_rs1, 1);

        // reset with loads queued
        iss_valid = 1'b1; iss_rd = 5'd12; rs2_addr = 5'd12;
        alu_wen = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h1212;
        step();
        iss_valid = 1'b0;
        ld_rd = 5'd13; ld_data = 32'h1313;
        step();
        do_reset(1);
        step();
        chk("post_reset_ld_ready", ld_ready, 1);
        chk("post_reset_busy_rs1", busy_rs1, 0);
        chk("post_reset_busy_rs2", busy_rs2, 0);
        step();

        // random traffic; blocked sources hold their inputs
        pend_alu = 1'b0;
        pend_ld  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pend_alu) begin
                alu_wen  = ($urandom_range(0, 99) < 55);
                alu_rd   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data = $urandom;
            end
            if (!pend_ld) begin
                ld_valid = ($urandom_range(0, 99) < 40);
                ld_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ld_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_rd    = 5'($urandom_range(0, 31));
            rs1_addr  = 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
                pend_alu = 1'b0;
                pend_ld  = 1'b0;
            end else begin
                step();
                pend_alu = m_stall;
                pend_ld  = m_ld_blocked;
            end
        end
        set_idle();
        for (int i = 0; i < 6; i++) step();
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the register file write port (`regwrite`, `writereg_addr`, `writedata`).
- Merges two writeback sources into one registered write stream:
  - single-cycle ALU results;
  - variable-latency load responses, buffered in a small FIFO.
- Keeps a pending-load scoreboard that the hazard unit queries with `rs1`/`rs2` addresses, so dependent instructions stall until their load data is written back.

Parameters:
- DEPTH, 2, load-response FIFO entries; power of 2, at least 2.
- AW, 1, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- alu_wen  in  1  ALU result valid this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU write not accepted this cycle; source holds its inputs.
- ld_valid  in  1  load response valid.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- ld_ready  out  1  FIFO can accept a response; equals FIFO not full.
- iss_valid  in  1  load issued to memory this cycle.
- iss_rd  in  5  destination of the issued load.
- rs1_addr  in  5  hazard query address.
- rs2_addr  in  5  hazard query address.
- busy_rs1  out  1  rs1_addr has a pending load (combinational).
- busy_rs2  out  1  rs2_addr has a pending load (combinational).
- regwrite  out  1  register-file write enable (registered).
- writereg_addr  out  5  register-file write address (registered).
- writedata  out  32  register-file write data (registered).

Behaviour:
- Reset (rst=0 at a rising edge):
  - regwrite=0, writereg_addr=0, writedata=0;
  - FIFO emptied: count=0, pointers=0;
  - all busy bits cleared.
  - Reset mid-operation discards queued loads and pending marks without producing writes.
- FIFO enqueue: ld_valid & ld_ready pushes {ld_rd, ld_data}. ld_valid while full is ignored; the source must hold.
- Arbitration, evaluated each cycle on the current FIFO head (not that cycle's enqueue):
  - FIFO full and alu_wen=1: FIFO head wins; alu_stall=1.
  - Otherwise alu_wen=1: ALU wins; alu_stall=0.
  - alu_wen=0 and FIFO non-empty: FIFO head wins (pop).
  - Neither: no write.
  - alu_stall is combinational and is 0 whenever alu_wen=0.
- Output register: the winner's {rd, data} is loaded at the edge.
  - regwrite=1 only if winner exists and rd!=0.
  - Writes to x0 are consumed (popped, accepted) but emit regwrite=0.
  - writereg_addr and writedata hold their last value when regwrite=0.
- Latency:
  - ALU accepted at cycle N -> regwrite at N+1.
  - Load enqueued at N -> earliest regwrite at N+2.
- Simultaneous enqueue and pop in one cycle: allowed; count unchanged. Pointers wrap modulo DEPTH.
- Scoreboard: 32-bit busy vector; bit 0 is never set.
  - Set: iss_valid & iss_rd!=0 sets busy[iss_rd].
  - Clear: a FIFO-head pop for rd clears busy[rd] at the same edge the output register loads.
  - Set and clear of the same register in one cycle: set wins (newer load outstanding).
  - ALU writes never modify busy bits.
- busy_rsX = busy[rsX_addr]; always 0 for address 0.
- Ordering: loads write back in arrival order. ALU writes may overtake queued loads; hazard logic uses busy bits to prevent WAW/RAW misuse.

Test Plan:
- Reset, then idle 3 cycles -> regwrite=0, ld_ready=1, busy_rs1=busy_rs2=0; alu_wen=1, rd=5, data=0xDEADBEEF -> next cycle regwrite=1, addr=5, data=0xDEADBEEF.
- iss_valid, iss_rd=7; next cycle rs1_addr=7 -> busy_rs1=1. Then ld_valid rd=7, data=0x12345678 with alu idle -> write of x7 two cycles later, busy_rs1=0 from that edge.
- Continuous alu_wen=1 (rd=3) while two loads arrive (DEPTH=2):
  - FIFO fills, ld_ready=0;
  - next cycle alu_stall=1 and a load writes back;
  - order of addresses observed matches priority rules;
  - no data lost.
- alu_wen rd=0 and a load with rd=0 -> both consumed, regwrite stays 0; iss_rd=0 -> busy_rs1 (rs1_addr=0) stays 0.
- Same cycle: pop of load rd=9 and iss_valid iss_rd=9 -> busy[9] remains 1 after the write.
- Two loads queued, rst=0 for one cycle -> no further regwrite, ld_ready=1, all busy 0.
